logic_pod_readback: RTL and testbench



---
 rtl/logic_pod_readback_if.sv | 41 ++++
 rtl/logic_pod_readback.sv | 183 ++++++++++++++++++
 tb/tb_logic_pod_readback.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_pod_readback_if.sv
// rtl/logic_pod_readback_if.sv - request, address-FIFO, return-beat and output-stream bundle for logic_pod_readback
//
// Ports (slave = readback block, master = host/memory side):
//   req_*            host request (valid/ready, channel, burst pointer, burst count)
//   addr_fifo_*      read address word push into the memory controller, free-slot count back
//   rdata_valid/rdata returned 128-bit beats, in order, no backpressure
//   out_*            output beat stream (valid/ready, data, last)
//   busy/done/err_unexpected  status
interface logic_pod_readback_if;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_channel;
    logic [21:0]  req_ptr;
    logic [15:0]  req_count;
    logic         addr_fifo_wr_en;
    logic [28:0]  addr_fifo_wr_data;
    logic [7:0]   addr_fifo_wr_size;
    logic         rdata_valid;
    logic [127:0] rdata;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         done;
    logic         err_unexpected;

    modport slave (
        input  req_valid, req_channel, req_ptr, req_count, addr_fifo_wr_size,
               rdata_valid, rdata, out_ready,
        output req_ready, addr_fifo_wr_en, addr_fifo_wr_data, out_valid, out_data,
               out_last, busy, done, err_unexpected
    );

    modport master (
        output req_valid, req_channel, req_ptr, req_count, addr_fifo_wr_size,
               rdata_valid, rdata, out_ready,
        input  req_ready, addr_fifo_wr_en, addr_fifo_wr_data, out_valid, out_data,
               out_last, busy, done, err_unexpected
    );
endinterface

// File: rtl/logic_pod_readback.sv
// rtl/logic_pod_readback.sv - credit-limited DRAM burst reader with buffered output stream
//
// Ports:
//   clk_ram_2x  sole clock
//   rst_n       asynchronous active-low reset
//   bus         logic_pod_readback_if.slave: request in, address words out, returned beats in,
//               buffered beat stream out, busy/done/err_unexpected status
module logic_pod_readback #(
    parameter int POD_NUMBER      = 0,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk_ram_2x,
    input  logic                  rst_n,
    logic_pod_readback_if.slave   bus
);
    localparam int DEPTH = 4 * MAX_OUTSTANDING;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic            POD_BIT     = (POD_NUMBER % 2) != 0;
    localparam logic [CW-1:0]   CREDITS_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0]   LAST_IDX    = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [2:0]    chan_q, chan_d;
    logic [21:0]   ptr_q, ptr_d;
    logic [15:0]   bursts_left_q, bursts_left_d;
    logic [17:0]   beats_left_q, beats_left_d;
    logic [CW-1:0] credits_q, credits_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [1:0]    rx_beat_q, rx_beat_d;
    logic [1:0]    pop_beat_q, pop_beat_d;
    logic          wr_en_q, wr_en_d;
    logic [28:0]   wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   fcount_q, fcount_d;
    logic [127:0]  mem [DEPTH];

    logic          space_ok, issue, push, pop, credit_ret, burst_rx;
    logic [2:0]    issue_chan;
    logic [21:0]   issue_ptr;

    // The first burst is issued straight from IDLE using the request fields so the
    // registered address push appears the cycle after acceptance. Credits are always
    // full in IDLE, but the check is kept for symmetry with ISSUE.
    assign space_ok   = bus.addr_fifo_wr_size > 8'd1;
    assign issue      = space_ok && credits_q != '0 &&
                        ((state_q == S_IDLE  && bus.req_valid && bus.req_count != 16'd0) ||
                         (state_q == S_ISSUE && bursts_left_q != 16'd0));
    assign issue_chan = (state_q == S_IDLE) ? bus.req_channel : chan_q;
    assign issue_ptr  = (state_q == S_IDLE) ? bus.req_ptr : ptr_q;

    // Beats with nothing outstanding are stray and never reach the buffer.
    assign push       = bus.rdata_valid && outstanding_q != '0;
    assign pop        = bus.out_valid && bus.out_ready;
    assign credit_ret = pop && pop_beat_q == 2'd3;
    assign burst_rx   = push && rx_beat_q == 2'd3;

    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        ptr_d         = ptr_q;
        bursts_left_d = bursts_left_q;
        beats_left_d  = pop ? beats_left_q - 18'd1 : beats_left_q;
        wr_en_d       = issue;
        wr_data_d     = issue ? {1'b0, POD_BIT, issue_chan, issue_ptr, 2'b00} : wr_data_q;
        done_d        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    chan_d        = bus.req_channel;
                    ptr_d         = bus.req_ptr + 22'(issue);
                    bursts_left_d = bus.req_count - 16'(issue);
                    beats_left_d  = {bus.req_count, 2'b00};
                    if (bus.req_count == 16'd0)
                        done_d = 1'b1;
                    else if (bursts_left_d == 16'd0)
                        state_d = S_DRAIN;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    ptr_d         = ptr_q + 22'd1;
                    bursts_left_d = bursts_left_q - 16'd1;
                    if (bursts_left_q == 16'd1)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && beats_left_q == 18'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        unique case ({issue, credit_ret})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
        outstanding_d = outstanding_q;
        unique case ({issue, burst_rx})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        fcount_d = fcount_q;
        unique case ({push, pop})
            2'b10:   fcount_d = fcount_q + (AW+1)'(1);
            2'b01:   fcount_d = fcount_q - (AW+1)'(1);
            default: fcount_d = fcount_q;
        endcase
        rx_beat_d  = push ? rx_beat_q + 2'd1 : rx_beat_q;
        pop_beat_d = pop ? pop_beat_q + 2'd1 : pop_beat_q;
        wptr_d     = push ? ((wptr_q == LAST_IDX) ? '0 : wptr_q + AW'(1)) : wptr_q;
        rptr_d     = pop  ? ((rptr_q == LAST_IDX) ? '0 : rptr_q + AW'(1)) : rptr_q;
        err_d      = err_q | (bus.rdata_valid && outstanding_q == '0);
    end

    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            chan_q        <= '0;
            ptr_q         <= '0;
            bursts_left_q <= '0;
            beats_left_q  <= '0;
            credits_q     <= CREDITS_MAX;
            outstanding_q <= '0;
            rx_beat_q     <= '0;
            pop_beat_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            fcount_q      <= '0;
        end else begin
            state_q       <= state_d;
            chan_q        <= chan_d;
            ptr_q         <= ptr_d;
            bursts_left_q <= bursts_left_d;
            beats_left_q  <= beats_left_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            rx_beat_q     <= rx_beat_d;
            pop_beat_q    <= pop_beat_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            done_q        <= done_d;
            err_q         <= err_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            fcount_q      <= fcount_d;
        end
    end

    // Buffer storage carries no reset; emptiness is tracked by fcount_q alone.
    always_ff @(posedge clk_ram_2x) begin
        if (push)
            mem[wptr_q] <= bus.rdata;
    end

    assign bus.req_ready         = state_q == S_IDLE;
    assign bus.busy              = state_q != S_IDLE;
    assign bus.addr_fifo_wr_en   = wr_en_q;
    assign bus.addr_fifo_wr_data = wr_data_q;
    assign bus.out_valid         = fcount_q != '0;
    assign bus.out_data          = bus.out_valid ? mem[rptr_q] : '0;
    assign bus.out_last          = bus.out_valid && beats_left_q == 18'd1;
    assign bus.done              = done_q;
    assign bus.err_unexpected    = err_q;
endmodule

// File: tb/tb_logic_pod_readback.sv
// tb/tb_logic_pod_readback.sv - self-checking bench for logic_pod_readback
module tb_logic_pod_readback;
    logic clk_ram_2x = 1'b0;
    logic rst_n;
    always #5 clk_ram_2x = ~clk_ram_2x;

    logic_pod_readback_if bus();

    logic_pod_readback #(.POD_NUMBER(1), .MAX_OUTSTANDING(8)) dut (
        .clk_ram_2x (clk_ram_2x),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    typedef struct {
        logic [2:0]  ch;
        logic [21:0] ptr;
        logic [15:0] cnt;
        logic [28:0] first_addr;
        logic [28:0] last_addr;
    } vec_t;

    vec_t vecs[5];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [28:0]  addr_log[$];
    logic [28:0]  rsp_q[$];
    int           addr_cyc[$];
    logic [127:0] pop_data[$];
    logic         pop_last[$];
    int           pop_cyc[$];
    int           done_cyc[$];
    logic         done_rdy[$];
    int resp_budget = 0;
    int inject_n = 0;
    int beats_in = 0;
    int max_buf = 0;

    function automatic logic [127:0] mk(input logic [28:0] a, input logic [1:0] b);
        return {3'b000, a, 30'd0, b, ~{3'b000, a}, 32'hC0FFEE00};
    endfunction

    function automatic logic [28:0] aw(input logic [2:0] ch, input logic [21:0] p);
        return {1'b0, 1'b1, ch, p, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk_ram_2x) cyc++;

    always @(negedge clk_ram_2x) begin
        if (rst_n === 1'b1) begin
            if (bus.addr_fifo_wr_en) begin
                addr_log.push_back(bus.addr_fifo_wr_data);
                rsp_q.push_back(bus.addr_fifo_wr_data);
                addr_cyc.push_back(cyc);
            end
            if (bus.rdata_valid) beats_in++;
            if (bus.out_valid && bus.out_ready) begin
                pop_data.push_back(bus.out_data);
                pop_last.push_back(bus.out_last);
                pop_cyc.push_back(cyc);
            end
            if (bus.done) begin
                done_cyc.push_back(cyc);
                done_rdy.push_back(bus.req_ready);
            end
            if (beats_in - pop_data.size() > max_buf) max_buf = beats_in - pop_data.size();
        end
    end

    // Memory model: serves one captured address at a time as 4 consecutive beats.
    initial begin
        logic [28:0] a;
        bus.rdata_valid = 1'b0;
        bus.rdata = '0;
        forever begin
            @(posedge clk_ram_2x);
            #1;
            bus.rdata_valid = 1'b0;
            if (inject_n > 0) begin
                bus.rdata_valid = 1'b1;
                bus.rdata = 128'hDEAD;
                inject_n--;
            end else if (resp_budget > 0 && rsp_q.size() > 0) begin
                a = rsp_q.pop_front();
                resp_budget--;
                for (int b = 0; b < 4; b++) begin
                    bus.rdata_valid = 1'b1;
                    bus.rdata = mk(a, 2'(b));
                    if (b < 3) begin
                        @(posedge clk_ram_2x);
                        #1;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        addr_log.delete(); rsp_q.delete(); addr_cyc.delete();
        pop_data.delete(); pop_last.delete(); pop_cyc.delete();
        done_cyc.delete(); done_rdy.delete();
        beats_in = 0; max_buf = 0;
    endtask

    task automatic do_req(input logic [2:0] ch, input logic [21:0] p, input logic [15:0] cnt,
                          output int acc);
        @(posedge clk_ram_2x);
        #1;
        bus.req_valid = 1'b1;
        bus.req_channel = ch;
        bus.req_ptr = p;
        bus.req_count = cnt;
        @(negedge clk_ram_2x);
        acc = cyc;
        chk("req_ready_at_accept", bus.req_ready, 1);
        @(posedge clk_ram_2x);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cyc.size() == 0 && n < 3000) begin
            @(posedge clk_ram_2x);
            n++;
        end
        repeat (3) @(posedge clk_ram_2x);
        @(negedge clk_ram_2x);
        checks++;
        if (done_cyc.size() == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within 3000 cycles", name);
        end
    endtask

    task automatic verify(input string name, input logic [2:0] ch, input logic [21:0] p,
                          input logic [15:0] cnt, input int acc,
                          input logic [28:0] first_addr, input logic [28:0] last_addr);
        int mism = 0;
        int lmism = 0;
        int nb = 4 * int'(cnt);
        chk({name, "_addr_count"}, addr_log.size(), cnt);
        chk({name, "_pop_count"}, pop_data.size(), nb);
        if (cnt != 0 && addr_log.size() == int'(cnt)) begin
            chk({name, "_first_addr"}, addr_log[0], first_addr);
            chk({name, "_last_addr"}, addr_log[cnt-1], last_addr);
            chk({name, "_first_addr_cycle"}, addr_cyc[0], acc + 1);
            for (int i = 0; i < int'(cnt); i++)
                if (addr_log[i] !== aw(ch, p + 22'(i))) mism++;
        end
        for (int j = 0; j < pop_data.size(); j++) begin
            if (pop_data[j] !== mk(aw(ch, p + 22'(j / 4)), 2'(j % 4))) mism++;
            if (pop_last[j] !== (j == nb - 1)) lmism++;
        end
        chk({name, "_data_order_mismatches"}, mism, 0);
        chk({name, "_last_flag_mismatches"}, lmism, 0);
        chk({name, "_done_pulses"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) begin
            chk({name, "_req_ready_with_done"}, done_rdy[0], 1);
            if (cnt == 0)
                chk({name, "_done_cycle"}, done_cyc[0], acc + 1);
            else if (pop_cyc.size() > 0)
                chk({name, "_done_cycle"}, done_cyc[0], pop_cyc[pop_cyc.size()-1] + 1);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int acc;
        clear_logs();
        resp_budget = 1000;
        bus.out_ready = 1'b1;
        do_req(v.ch, v.ptr, v.cnt, acc);
        wait_done(name);
        verify(name, v.ch, v.ptr, v.cnt, acc, v.first_addr, v.last_addr);
    endtask

    initial begin
        int acc;
        int seen;
        vecs[0] = '{ch: 3'd5, ptr: 22'h000010, cnt: 16'd3,  first_addr: 29'h0D000040, last_addr: 29'h0D000048};
        vecs[1] = '{ch: 3'd0, ptr: 22'h3FFFFF, cnt: 16'd2,  first_addr: 29'h08FFFFFC, last_addr: 29'h08000000};
        vecs[2] = '{ch: 3'd7, ptr: 22'h123456, cnt: 16'd1,  first_addr: 29'h0F48D158, last_addr: 29'h0F48D158};
        vecs[3] = '{ch: 3'd2, ptr: 22'h000100, cnt: 16'd12, first_addr: 29'h0A000400, last_addr: 29'h0A00042C};
        vecs[4] = '{ch: 3'd2, ptr: 22'h0003AB, cnt: 16'd0,  first_addr: 29'h0,        last_addr: 29'h0};

        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_channel = '0;
        bus.req_ptr = '0;
        bus.req_count = '0;
        bus.addr_fifo_wr_size = 8'd16;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk_ram_2x);
        @(negedge clk_ram_2x);
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_wr_en", bus.addr_fifo_wr_en, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_err", bus.err_unexpected, 0);
        @(posedge clk_ram_2x);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++)
            run_vec($sformatf("vec%0d", k), vecs[k]);

        // Address FIFO nearly full: nothing may be pushed until space returns.
        clear_logs();
        resp_budget = 1000;
        bus.out_ready = 1'b1;
        bus.addr_fifo_wr_size = 8'd1;
        do_req(3'd0, 22'h000000, 16'd2, acc);
        repeat (10) @(posedge clk_ram_2x);
        @(negedge clk_ram_2x);
        chk("thresh_no_push", addr_log.size(), 0);
        chk("thresh_busy", bus.busy, 1);
        @(posedge clk_ram_2x);
        #1;
        bus.addr_fifo_wr_size = 8'd16;
        wait_done("thresh");
        chk("thresh_addr0", addr_log.size() > 0 ? addr_log[0] : 29'h1FFFFFFF, 29'h08000000);
        chk("thresh_pops", pop_data.size(), 8);

        // Credit limit: no data returned, so only MAX_OUTSTANDING bursts go out.
        clear_logs();
        resp_budget = 0;
        bus.out_ready = 1'b1;
        do_req(3'd1, 22'h000200, 16'd20, acc);
        repeat (40) @(posedge clk_ram_2x);
        @(negedge clk_ram_2x);
        chk("credit_addr_count", addr_log.size(), 8);
        chk("credit_busy", bus.busy, 1);
        resp_budget = 1;
        repeat (30) @(posedge clk_ram_2x);
        @(negedge clk_ram_2x);
        chk("credit_one_more", addr_log.size(), 9);
        resp_budget = 1000;
        wait_done("credit");
        verify("credit", 3'd1, 22'h000200, 16'd20, acc, 29'h09000800, 29'h0900084C);

        // Backpressure: all 32 beats buffered, then drained in order.
        clear_logs();
        resp_budget = 1000;
        bus.out_ready = 1'b0;
        do_req(3'd4, 22'h000777, 16'd8, acc);
        repeat (100) @(posedge clk_ram_2x);
        @(negedge clk_ram_2x);
        chk("bp_no_pop", pop_data.size(), 0);
        chk("bp_max_buf_le32", max_buf <= 32, 1);
        chk("bp_beats_in", beats_in, 32);
        chk("bp_out_valid", bus.out_valid, 1);
        @(posedge clk_ram_2x);
        #1;
        bus.out_ready = 1'b1;
        wait_done("bp");
        verify("bp", 3'd4, 22'h000777, 16'd8, acc, 29'h0C001DDC, 29'h0C001DF8);

        // Stray beat while idle.
        clear_logs();
        inject_n = 1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_ram_2x);
            if (bus.out_valid) seen++;
        end
        chk("stray_err", bus.err_unexpected, 1);
        chk("stray_out_valid_cycles", seen, 0);

        // Asynchronous reset in the middle of ISSUE.
        clear_logs();
        resp_budget = 0;
        do_req(3'd6, 22'h000040, 16'd20, acc);
        repeat (2) @(posedge clk_ram_2x);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_en", bus.addr_fifo_wr_en, 0);
        chk("rst_wr_data", bus.addr_fifo_wr_data, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data[63:0], 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err_unexpected, 0);
        @(posedge clk_ram_2x);
        #1;
        rst_n = 1'b1;
        rsp_q.delete();
        run_vec("after_rst", '{ch: 3'd3, ptr: 22'h000050, cnt: 16'd2,
                               first_addr: 29'h0B000140, last_addr: 29'h0B000144});
        chk("after_rst_err", bus.err_unexpected, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
